// File: rtl/countdown_hex_driver.sv
// countdown_hex_driver
// --------------------
// Loadable NDIG-digit BCD down-counter with active-low seven-segment outputs.
// A start value is loaded, armed with `start`, and decremented once per
// `decr` tick while running. Completion is flagged when the count reaches
// zero.
//
// Ports:
//   clk        in   system clock (rising edge)
//   reset      in   synchronous active-high reset
//   load       in   capture load_val (nibbles > 9 clamp to 9), go to IDLE
//   load_val   in   4*NDIG BCD start value, digit 0 least significant
//   start      in   arm the countdown (IDLE -> RUN, or DONE if count is 0)
//   decr       in   decrement tick, honoured only in RUN
//   hexout     out  7*NDIG active-low segments, per digit bit order g..a
//   running    out  high in RUN
//   done       out  high in DONE
//   borrowout  out  combinational: this decr is the final one (count 0..01)
module countdown_hex_driver #(
  parameter int NDIG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              start,
  input  logic              decr,
  output logic [7*NDIG-1:0] hexout,
  output logic              running,
  output logic              done,
  output logic              borrowout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [NDIG-1:0] LSB_MASK = NDIG'(1);

  state_t      state_q;
  logic        running_q;
  logic        done_q;
  logic [3:0]  cnt_q   [NDIG];
  logic [3:0]  dec_d   [NDIG];
  logic [3:0]  clamp_d [NDIG];
  logic [NDIG:0]   borrow;
  logic [NDIG-1:0] dig_zero;
  logic        is_zero;
  logic        is_one;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111; // digits never leave 0..9
    endcase
    return s;
  endfunction

  // Digit 0 always receives the borrow; it ripples up through zero digits.
  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      assign dig_zero[gi]   = (cnt_q[gi] == 4'd0);
      assign borrow[gi+1]   = borrow[gi] & dig_zero[gi];
      assign dec_d[gi]      = !borrow[gi]   ? cnt_q[gi] :
                              dig_zero[gi]  ? 4'd9      : cnt_q[gi] - 4'd1;
      assign clamp_d[gi]    = (load_val[4*gi +: 4] > 4'd9) ? 4'd9
                                                           : load_val[4*gi +: 4];
      assign hexout[7*gi +: 7] = seg7(cnt_q[gi]);
    end
  endgenerate

  assign is_zero = &dig_zero;
  // All upper digits zero and digit 0 equal to one.
  assign is_one  = (cnt_q[0] == 4'd1) && (&(dig_zero | LSB_MASK));

  assign borrowout = (state_q == RUN) && decr && is_one;
  assign running   = running_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) cnt_q[i] <= 4'd0;
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < NDIG; i++) cnt_q[i] <= clamp_d[i];
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (decr) begin
            for (int i = 0; i < NDIG; i++) cnt_q[i] <= dec_d[i];
            // The final decrement lands on zero and finishes at the same edge.
            if (is_one) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          // Count is already zero; only load or reset leave this state.
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_hex_driver.sv
module tb_countdown_hex_driver;

  logic        clk;
  logic        reset;
  logic        load;
  logic [7:0]  load_val;
  logic        start;
  logic        decr;
  logic [13:0] hexout;
  logic        running;
  logic        done;
  logic        borrowout;

  countdown_hex_driver #(.NDIG(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .decr      (decr),
    .hexout    (hexout),
    .running   (running),
    .done      (done),
    .borrowout (borrowout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: count as a plain integer, mode 0=idle 1=run 2=done.
  int m_cnt  = 0;
  int m_mode = 0;
  bit model_valid = 0;
  logic [6:0] seg_tab [10];

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
  end

  function automatic logic [13:0] exp_hex(input int v);
    return {seg_tab[(v / 10) % 10], seg_tab[v % 10]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_mode = 0; model_valid = 1;
    end else if (load) begin
      m_cnt  = ((load_val[7:4] > 9) ? 9 : int'(load_val[7:4])) * 10
             + ((load_val[3:0] > 9) ? 9 : int'(load_val[3:0]));
      m_mode = 0;
    end else if (m_mode == 0 && start) begin
      m_mode = (m_cnt == 0) ? 2 : 1;
    end else if (m_mode == 1 && decr) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_mode = 2;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("hexout",    hexout,    exp_hex(m_cnt));
      check("running",   running,   m_mode == 1);
      check("done",      done,      m_mode == 2);
      check("borrowout", borrowout, (m_mode == 1) && decr && (m_cnt == 1));
    end
  end

  task automatic cyc(input logic r, input logic l, input logic [7:0] lv,
                     input logic s, input logic d);
    reset = r; load = l; load_val = lv; start = s; decr = d;
    @(posedge clk); #1;
    reset = 0; load = 0; start = 0; decr = 0;
  endtask

  initial begin
    reset = 1; load = 0; load_val = 8'h00; start = 0; decr = 0;
    cyc(1, 0, 8'h00, 0, 0);
    check("rst_hex",  hexout,  {7'b1000000, 7'b1000000});
    check("rst_run",  running, 1'b0);
    check("rst_done", done,    1'b0);

    // 42 -> 39
    cyc(0, 1, 8'h42, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    repeat (3) cyc(0, 0, 8'h00, 0, 1);
    check("dec39_hex", hexout,  {7'b0110000, 7'b0010000});
    check("dec39_run", running, 1'b1);

    // 10 -> 09 borrow path
    cyc(0, 1, 8'h10, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    check("borrow09_hex", hexout, {7'b1000000, 7'b0010000});

    // 02 -> 00 with borrowout on the final decrement only
    cyc(0, 1, 8'h02, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    decr = 1; #1;
    check("bo_first", borrowout, 1'b0);
    @(posedge clk); #1;
    check("bo_final", borrowout, 1'b1);
    @(posedge clk); #1;
    decr = 0;
    check("fin_done", done,    1'b1);
    check("fin_run",  running, 1'b0);
    check("fin_hex",  hexout,  {7'b1000000, 7'b1000000});
    cyc(0, 0, 8'h00, 0, 1);
    check("fin_hold", hexout,  {7'b1000000, 7'b1000000});

    // start at zero goes straight to DONE
    cyc(0, 1, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    check("zero_done", done,    1'b1);
    check("zero_run",  running, 1'b0);

    // load beats decr/start in RUN; then clamp
    cyc(0, 1, 8'h57, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 1, 8'h93, 1, 1);
    check("ldpri_hex", hexout,  {7'b0010000, 7'b0110000});
    check("ldpri_run", running, 1'b0);
    cyc(0, 0, 8'h00, 0, 1);
    check("idle_decr", hexout,  {7'b0010000, 7'b0110000});
    cyc(0, 1, 8'hAF, 0, 0);
    check("clamp_hex", hexout,  {7'b0010000, 7'b0010000});

    // reset beats decr mid-count
    cyc(0, 1, 8'h30, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'h00, 0, 1);
    check("rstmid_hex",  hexout,  {7'b1000000, 7'b1000000});
    check("rstmid_run",  running, 1'b0);
    check("rstmid_done", done,    1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic r, l, s, d;
      logic [7:0] lv;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 14) == 0);
      s  = ($urandom_range(0, 7) == 0);
      d  = s ? 1'b0 : ($urandom_range(0, 2) != 0);
      lv[7:4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      lv[3:0] = 4'($urandom_range(0, 15));
      cyc(r, l, lv, s, d);
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
